dds_phase_gen: RTL and testbench

- Phase-accumulator front end of the DDS chain, directly upstream of the 8-bit sine LUT.
- Each enabled clock it advances a 32-bit phase accumulator by a frequency tuning word (FTW) and adds a phase offset.
- It presents the resulting 8-bit address on `lookup`, registered, to the LUT's `lookup` input.
- Supports FTW reload via a valid/ready handshake, a linear frequency sweep (chirp), and a synchronous phase clear.

---
 rtl/dds_pkg.sv | 18 +
 rtl/dds_phase_gen.sv | 126 ++++++++++++
 tb/tb_dds_phase_gen.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase generator: default widths, the
// sweep FSM state encoding and the accumulator increment that moves the
// LUT address by exactly one entry.
package dds_pkg;

    localparam int DDS_ACC_W  = 32;
    localparam int DDS_ADDR_W = 8;

    // Two operating modes: fixed frequency, or linear FTW ramp (chirp).
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // Tuning word that advances the LUT address by one entry per cycle.
    localparam logic [63:0] FTW_PER_STEP = 64'd1 << (DDS_ACC_W - DDS_ADDR_W);

endpackage

// File: rtl/dds_phase_gen.sv
// Phase accumulator front end of the DDS chain. Advances a phase
// accumulator by the tuning word on enabled cycles, adds a phase offset to
// the top address bits and presents a registered address to the sine LUT.
// The tuning word is reloaded through a valid/ready handshake and can be
// ramped linearly towards a stop value (chirp).
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int ACC_W  = DDS_ACC_W,
    parameter int ADDR_W = DDS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              phase_clr,
    input  logic [ACC_W-1:0]  ftw_in,
    input  logic              ftw_valid,
    output logic              ftw_ready,
    input  logic              sweep_en,
    input  logic [ACC_W-1:0]  sweep_step,
    input  logic [ACC_W-1:0]  sweep_stop,
    input  logic [ADDR_W-1:0] phase_off,
    output logic [ADDR_W-1:0] lookup,
    output logic              wrap,
    output logic              sweep_done
);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    ftw_q, ftw_d;
    logic [ADDR_W-1:0]   lookup_q, lookup_d;
    logic                wrap_q, wrap_d;
    logic                sweep_done_q, sweep_done_d;
    logic                ftw_ready_q, ftw_ready_d;

    // One extra bit on both sums: the accumulator carry is the wrap flag,
    // and the sweep compare must see a tuning word that overflows ACC_W.
    logic [ACC_W:0]      acc_sum;
    logic [ACC_W:0]      sweep_sum;
    logic                ftw_accept;

    assign acc_sum    = {1'b0, acc_q} + {1'b0, ftw_q};
    assign sweep_sum  = {1'b0, ftw_q} + {1'b0, sweep_step};
    assign ftw_accept = ftw_valid & ftw_ready_q;

    // Accumulator update: clear wins over the increment and ignores en.
    always_comb begin
        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (phase_clr) begin
            acc_d  = '0;
            wrap_d = 1'b0;
        end else if (en) begin
            acc_d  = acc_sum[ACC_W-1:0];
            wrap_d = acc_sum[ACC_W];
        end
    end

    // Mode FSM and tuning word: sweep ramp while in SWEEP, reload on accept.
    always_comb begin
        state_d      = state_q;
        ftw_d        = ftw_q;
        sweep_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ftw_accept) begin
                    ftw_d = ftw_in;
                    if (sweep_en) begin
                        state_d = ST_SWEEP;
                    end
                end
            end
            ST_SWEEP: begin
                // en low freezes the ramp; ready is low so no reload here.
                if (en) begin
                    if (sweep_sum >= {1'b0, sweep_stop}) begin
                        ftw_d        = sweep_stop;
                        sweep_done_d = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        ftw_d = sweep_sum[ACC_W-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Ready is registered but follows the state we are about to enter,
        // so it drops on the very edge a sweep is started.
        ftw_ready_d = (state_d == ST_RUN);
    end

    // LUT address from the new accumulator value; phase_off is applied
    // every edge so offset changes show up even while en is low.
    always_comb begin
        lookup_d = acc_d[ACC_W-1 -: ADDR_W] + phase_off;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            ftw_q        <= '0;
            lookup_q     <= '0;
            wrap_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            ftw_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            lookup_q     <= lookup_d;
            wrap_q       <= wrap_d;
            sweep_done_q <= sweep_done_d;
            ftw_ready_q  <= ftw_ready_d;
        end
    end

    assign lookup     = lookup_q;
    assign wrap       = wrap_q;
    assign sweep_done = sweep_done_q;
    assign ftw_ready  = ftw_ready_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: directed scenarios plus random
// stimulus, all compared against a behavioural model using plain integer
// arithmetic on the phase and tuning word.
module tb_dds_phase_gen;
    import dds_pkg::*;

    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        phase_clr;
    logic [31:0] ftw_in;
    logic        ftw_valid;
    logic        ftw_ready;
    logic        sweep_en;
    logic [31:0] sweep_step;
    logic [31:0] sweep_stop;
    logic [7:0]  phase_off;
    logic [7:0]  lookup;
    logic        wrap;
    logic        sweep_done;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    longint unsigned m_acc;
    longint unsigned m_ftw;
    bit              m_sweeping;
    bit              m_ready;
    bit              m_wrap;
    bit              m_done;
    logic [7:0]      m_lookup;

    dds_phase_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .phase_clr  (phase_clr),
        .ftw_in     (ftw_in),
        .ftw_valid  (ftw_valid),
        .ftw_ready  (ftw_ready),
        .sweep_en   (sweep_en),
        .sweep_step (sweep_step),
        .sweep_stop (sweep_stop),
        .phase_off  (phase_off),
        .lookup     (lookup),
        .wrap       (wrap),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc      = 0;
        m_ftw      = 0;
        m_sweeping = 0;
        m_ready    = 0;
        m_wrap     = 0;
        m_done     = 0;
        m_lookup   = 8'd0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        longint unsigned next_phase;
        longint unsigned ramp;
        next_phase = m_acc + m_ftw;
        m_wrap = 0;
        if (phase_clr) begin
            m_acc = 0;
        end else if (en) begin
            m_wrap = (next_phase >= MOD);
            m_acc  = next_phase % MOD;
        end
        m_done = 0;
        if (m_sweeping && en) begin
            ramp = m_ftw + longint'(sweep_step);
            if (ramp >= longint'(sweep_stop)) begin
                m_ftw      = longint'(sweep_stop);
                m_done     = 1;
                m_sweeping = 0;
            end else begin
                m_ftw = ramp;
            end
        end else if (ftw_valid && m_ready) begin
            m_ftw = longint'(ftw_in);
            if (sweep_en) m_sweeping = 1;
        end
        m_ready  = !m_sweeping;
        m_lookup = 8'((m_acc / FTW_PER_STEP + longint'(phase_off)) % 256);
    endtask

    // Clock edge: model follows the DUT, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; phase_clr = 0; ftw_in = 0; ftw_valid = 0; sweep_en = 0;
        sweep_step = 0; sweep_stop = 0; phase_off = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #3;
        if ({lookup, wrap, ftw_ready, sweep_done} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=000", {lookup, wrap, ftw_ready, sweep_done});
        end
        n_cmp++;
        @(negedge clk);
        rst_n = 1;
        tick();
        if (ftw_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_rise got=%b exp=1", ftw_ready);
        end
        n_cmp++;
    endtask

    task automatic test_ramp();
        int wraps = 0;
        en = 1; ftw_valid = 1; ftw_in = 32'h0100_0000;
        for (int k = 0; k < 260; k++) begin
            tick();
            ftw_valid = 0;
            if (wrap) wraps++;
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}
                || lookup !== 8'(k) || wrap !== (k == 256)) begin
                n_err++;
                $display("FAIL ramp cyc=%0d got lookup=%0d wrap=%b exp lookup=%0d wrap=%b",
                         k, lookup, wrap, k % 256, (k == 256));
            end
            n_cmp++;
        end
        if (wraps != 1) begin
            n_err++;
            $display("FAIL ramp_wrap_count got=%0d exp=1", wraps);
        end
        n_cmp++;
    endtask

    task automatic test_half_rate();
        int off;
        phase_clr = 1; ftw_valid = 1; ftw_in = 32'h8000_0000; phase_off = 0; en = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            phase_clr = 0; ftw_valid = 0;
            off = (k >= 6) ? 64 : 0;
            if (k == 5) phase_off = 8'd64;
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}
                || lookup !== 8'(((k % 2) ? 128 : 0) + off)
                || wrap !== (k > 0 && (k % 2) == 0)) begin
                n_err++;
                $display("FAIL half_rate cyc=%0d got lookup=%0d wrap=%b exp lookup=%0d wrap=%b",
                         k, lookup, wrap, ((k % 2) ? 128 : 0) + off, (k > 0 && (k % 2) == 0));
            end
            n_cmp++;
        end
    endtask

    task automatic test_clear_with_load();
        en = 1; ftw_valid = 1; ftw_in = 32'h0100_0000; phase_off = 0;
        repeat (5) tick();
        ftw_valid = 0;
        phase_off = 8'd5; phase_clr = 1; ftw_valid = 1; ftw_in = 32'h0200_0000;
        for (int k = 0; k < 6; k++) begin
            tick();
            phase_clr = 0; ftw_valid = 0;
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}
                || lookup !== 8'(5 + 2 * k) || wrap !== 1'b0) begin
                n_err++;
                $display("FAIL clear_load cyc=%0d got lookup=%0d wrap=%b exp lookup=%0d wrap=0",
                         k, lookup, wrap, 5 + 2 * k);
            end
            n_cmp++;
        end
    endtask

    task automatic test_sweep();
        int low_cnt = 0;
        int done_cnt = 0;
        en = 1; phase_off = 0;
        ftw_valid = 1; sweep_en = 1; ftw_in = 32'h0100_0000;
        sweep_step = 32'h0100_0000; sweep_stop = 32'h0400_0000;
        for (int k = 0; k < 7; k++) begin
            tick();
            ftw_valid = 0; sweep_en = 0;
            if (!ftw_ready) low_cnt++;
            if (sweep_done) done_cnt++;
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}) begin
                n_err++;
                $display("FAIL sweep cyc=%0d got=%h exp=%h", k,
                         {lookup, wrap, ftw_ready, sweep_done}, {m_lookup, m_wrap, m_ready, m_done});
            end
            n_cmp++;
        end
        if (low_cnt != 3 || done_cnt != 1) begin
            n_err++;
            $display("FAIL sweep_counts got ready_low=%0d done=%0d exp ready_low=3 done=1",
                     low_cnt, done_cnt);
        end
        n_cmp++;
    endtask

    task automatic test_overflow_sweep();
        en = 1;
        ftw_valid = 1; sweep_en = 1; ftw_in = 32'hFFFF_0000;
        sweep_step = 32'h0002_0000; sweep_stop = 32'hFFFF_FFFF;
        tick();
        ftw_valid = 0; sweep_en = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}
                || (k == 0 && {ftw_ready, sweep_done} !== 2'b11)) begin
                n_err++;
                $display("FAIL overflow_sweep cyc=%0d got=%h exp=%h", k,
                         {lookup, wrap, ftw_ready, sweep_done}, {m_lookup, m_wrap, m_ready, m_done});
            end
            n_cmp++;
        end
    endtask

    task automatic test_freeze();
        logic [7:0] held;
        en = 1; phase_off = 0;
        ftw_valid = 1; sweep_en = 1; ftw_in = 32'h0100_0000;
        sweep_step = 32'h0010_0000; sweep_stop = 32'hF000_0000;
        tick();
        ftw_valid = 0; sweep_en = 0;
        repeat (3) tick();
        held = m_lookup;
        en = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}
                || lookup !== held || ftw_ready !== 1'b0 || sweep_done !== 1'b0) begin
                n_err++;
                $display("FAIL freeze cyc=%0d got lookup=%0d ready=%b done=%b exp lookup=%0d ready=0 done=0",
                         k, lookup, ftw_ready, sweep_done, held);
            end
            n_cmp++;
        end
        phase_off = 8'd3;
        tick();
        if (lookup !== 8'(held + 3)) begin
            n_err++;
            $display("FAIL freeze_offset got=%0d exp=%0d", lookup, 8'(held + 3));
        end
        n_cmp++;
        en = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}) begin
                n_err++;
                $display("FAIL unfreeze cyc=%0d got=%h exp=%h", k,
                         {lookup, wrap, ftw_ready, sweep_done}, {m_lookup, m_wrap, m_ready, m_done});
            end
            n_cmp++;
        end
    endtask

    // Runs straight after test_freeze, so the long sweep is still active.
    task automatic test_reset_mid_sweep();
        int done_cnt = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        if (lookup !== 8'd0 || ftw_ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got lookup=%0d ready=%b exp lookup=0 ready=0", lookup, ftw_ready);
        end
        n_cmp++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sweep_done) done_cnt++;
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}) begin
                n_err++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", k,
                         {lookup, wrap, ftw_ready, sweep_done}, {m_lookup, m_wrap, m_ready, m_done});
            end
            n_cmp++;
        end
        if (done_cnt != 0) begin
            n_err++;
            $display("FAIL reset_abandon got done=%0d exp=0", done_cnt);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            en         = ($urandom_range(0, 3) != 0);
            phase_clr  = ($urandom_range(0, 15) == 0);
            ftw_valid  = ($urandom_range(0, 3) == 0);
            sweep_en   = $urandom_range(0, 1);
            ftw_in     = $urandom;
            sweep_step = $urandom | 32'h0400_0000;
            sweep_stop = $urandom;
            phase_off  = 8'($urandom);
            tick();
            if ({lookup, wrap, ftw_ready, sweep_done} !== {m_lookup, m_wrap, m_ready, m_done}) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k,
                         {lookup, wrap, ftw_ready, sweep_done}, {m_lookup, m_wrap, m_ready, m_done});
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_half_rate();
        test_clear_with_load();
        test_sweep();
        test_overflow_sweep();
        test_freeze();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
